// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment time display: active-low segment
// patterns {g,f,e,d,c,b,a}, the digit index type and special digit positions.
package seg7_pkg;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   typedef logic [2:0] digit_idx_t;

   // Digits that carry the HH.MM.SS separator dots, and the hour-tens digit.
   localparam digit_idx_t COLON_DIGIT_LO = 3'd2;
   localparam digit_idx_t COLON_DIGIT_HI = 3'd4;
   localparam digit_idx_t LZ_DIGIT       = 3'd5;

endpackage

// File: rtl/seg7_time_scanner_if.sv
// BCD time digits and display controls from the counter chain to the scanner.
// The counters (master) drive every signal; the scanner (slave) only reads.
interface seg7_time_scanner_if;

   logic [3:0] right_sec;
   logic [3:0] left_sec;
   logic [3:0] right_min;
   logic [3:0] left_min;
   logic [3:0] right_hr;
   logic [3:0] left_hr;
   logic [5:0] blink_mask;
   logic       blink_tick;
   logic       lz_blank_en;
   logic       colon_en;

   modport master (
      output right_sec, left_sec, right_min, left_min, right_hr, left_hr,
      output blink_mask, blink_tick, lz_blank_en, colon_en
   );

   modport slave (
      input right_sec, left_sec, right_min, left_min, right_hr, left_hr,
      input blink_mask, blink_tick, lz_blank_en, colon_en
   );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 go dark
// so a transient pre-carry value never shows as a garbage glyph.
module bcd_to_7seg
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_OFF;
      case (bcd)
         4'd0: seg_n = SEG_0;
         4'd1: seg_n = SEG_1;
         4'd2: seg_n = SEG_2;
         4'd3: seg_n = SEG_3;
         4'd4: seg_n = SEG_4;
         4'd5: seg_n = SEG_5;
         4'd6: seg_n = SEG_6;
         4'd7: seg_n = SEG_7;
         4'd8: seg_n = SEG_8;
         4'd9: seg_n = SEG_9;
         default: seg_n = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_time_scanner.sv
// Multiplexes six BCD time digits onto a common-anode display with blink,
// hour-tens leading-zero blanking and a short all-off gap between digits.
module seg7_time_scanner
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16,
   parameter int NUM_DIGITS   = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   seg7_time_scanner_if.slave    tif,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0]         LAST_COUNT = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0]         BLANK_END  = CW'(BLANK_CYCLES);
   localparam digit_idx_t            LAST_IDX   = digit_idx_t'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

   logic [CW-1:0]         count_q, count_d;
   digit_idx_t            idx_q, idx_d;
   logic                  phase_q, phase_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic [3:0] digit_val;
   logic       blink_sel;
   logic [6:0] dec_seg;
   logic       slot_blank;
   logic       blink_blank;
   logic       lz_blank;

   always_comb begin
      digit_val = tif.left_hr;
      blink_sel = tif.blink_mask[5];
      case (idx_q)
         3'd0: begin digit_val = tif.right_sec; blink_sel = tif.blink_mask[0]; end
         3'd1: begin digit_val = tif.left_sec;  blink_sel = tif.blink_mask[1]; end
         3'd2: begin digit_val = tif.right_min; blink_sel = tif.blink_mask[2]; end
         3'd3: begin digit_val = tif.left_min;  blink_sel = tif.blink_mask[3]; end
         3'd4: begin digit_val = tif.right_hr;  blink_sel = tif.blink_mask[4]; end
         default: begin digit_val = tif.left_hr; blink_sel = tif.blink_mask[5]; end
      endcase
   end

   bcd_to_7seg u_dec (
      .bcd   (digit_val),
      .seg_n (dec_seg)
   );

   always_comb begin
      count_d = count_q + CW'(1);
      idx_d   = idx_q;
      if (count_q == LAST_COUNT) begin
         count_d = '0;
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 3'd1;
      end
      // A tick on the advance cycle lands before the new slot's first output.
      phase_d = phase_q ^ tif.blink_tick;

      slot_blank  = (count_q < BLANK_END);
      blink_blank = phase_q & blink_sel;
      lz_blank    = tif.lz_blank_en && (idx_q == LZ_DIGIT) && (tif.left_hr == 4'd0);

      an_d  = slot_blank ? '1 : ~(AN_ONE << idx_q);
      seg_d = (slot_blank || blink_blank || lz_blank) ? SEG_OFF : dec_seg;
      dp_d  = !(tif.colon_en && ((idx_q == COLON_DIGIT_LO) || (idx_q == COLON_DIGIT_HI))
                && !slot_blank && !blink_blank);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         idx_q   <= '0;
         phase_q <= 1'b0;
         an_q    <= '1;
         seg_q   <= SEG_OFF;
         dp_q    <= 1'b1;
      end else begin
         count_q <= count_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_time_scanner.sv
// Bench for seg7_time_scanner: directed scenarios plus random traffic, each
// cycle compared against a slot/offset arithmetic model of the display.
module tb_seg7_time_scanner;

   localparam int RD = 40;
   localparam int BC = 4;
   localparam int ND = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   seg7_time_scanner_if tif ();

   seg7_time_scanner #(
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC),
      .NUM_DIGITS   (ND)
   ) dut (
      .clk (clk),
      .rst (rst),
      .tif (tif),
      .an  (an),
      .seg (seg),
      .dp  (dp)
   );

   always #5 clk = ~clk;

   logic [13:0] exp_q[$];
   int          pass_cnt  = 0;
   int          total_cnt = 0;
   int          mc;
   bit          mph;
   logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Expected pins after the next edge: slot = cycle / RD, offset = cycle % RD.
   function automatic logic [13:0] model_out();
      int         off;
      int         d;
      logic [3:0] v;
      logic [5:0] a;
      logic [6:0] s;
      logic       b;
      logic       p;
      off = mc % RD;
      d   = (mc / RD) % ND;
      case (d)
         0: v = tif.right_sec;
         1: v = tif.left_sec;
         2: v = tif.right_min;
         3: v = tif.left_min;
         4: v = tif.right_hr;
         default: v = tif.left_hr;
      endcase
      if (off < BC) return {6'h3F, 7'h7F, 1'b1};
      a    = 6'h3F;
      a[d] = 1'b0;
      b    = mph && tif.blink_mask[d];
      if (b || (tif.lz_blank_en && d == 5 && v == 4'd0) || v > 4'd9) s = 7'h7F;
      else s = seg_tab[v];
      p = !(tif.colon_en && (d == 2 || d == 4) && !b);
      return {a, s, p};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total_cnt++;
      assert (got === exp) pass_cnt++;
      else $error("FAIL %s: got %h expected %h (model cycle %0d)", tag, got, exp, mc);
   endtask

   task automatic step();
      logic [13:0] e;
      exp_q.push_back(model_out());
      @(posedge clk);
      mc++;
      if (tif.blink_tick) mph = ~mph;
      @(negedge clk);
      e = exp_q.pop_front();
      check("an",  {2'b00, an},  {2'b00, e[13:8]});
      check("seg", {1'b0, seg},  {1'b0, e[7:1]});
      check("dp",  {7'd0, dp},   {7'd0, e[0]});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_blink();
      tif.blink_tick = 1'b1;
      step();
      tif.blink_tick = 1'b0;
   endtask

   task automatic set_time(input logic [3:0] h1, h0, m1, m0, s1, s0);
      tif.left_hr  = h1; tif.right_hr  = h0;
      tif.left_min = m1; tif.right_min = m0;
      tif.left_sec = s1; tif.right_sec = s0;
   endtask

   initial begin
      rst = 1'b1;
      set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
      tif.blink_mask  = 6'b0;
      tif.blink_tick  = 1'b0;
      tif.lz_blank_en = 1'b0;
      tif.colon_en    = 1'b0;
      mc  = 0;
      mph = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_an",  {2'b00, an}, 8'h3F);
      check("reset_seg", {1'b0, seg}, 8'h7F);
      check("reset_dp",  {7'd0, dp},  8'h01);
      rst = 1'b0;

      // Static scan of 12:34:56 through the 5->0 wrap.
      run(ND * RD + RD);

      // Asynchronous reset in the middle of digit 3's active window.
      while (!(((mc / RD) % ND) == 3 && (mc % RD) == 20)) step();
      #2 rst = 1'b1;
      #1;
      check("async_rst_an",  {2'b00, an}, 8'h3F);
      check("async_rst_seg", {1'b0, seg}, 8'h7F);
      check("async_rst_dp",  {7'd0, dp},  8'h01);
      @(negedge clk);
      rst = 1'b0;
      mc  = 0;
      mph = 1'b0;
      run(ND * RD + RD);

      // Blink digits 0-1; first pulse coincides with an index advance.
      tif.blink_mask = 6'b000011;
      while ((mc % RD) != RD - 1) step();
      pulse_blink();
      run(ND * RD);
      pulse_blink();
      run(ND * RD);
      tif.blink_mask = 6'b0;

      // Leading-zero blank of hour tens plus separator dots.
      set_time(4'd0, 4'd7, 4'd5, 4'd9, 4'd0, 4'd8);
      tif.lz_blank_en = 1'b1;
      tif.colon_en    = 1'b1;
      run(ND * RD + 10);

      // One-cycle invalid code on digit 0 during its active window.
      while (!(((mc / RD) % ND) == 0 && (mc % RD) == 20)) step();
      tif.right_sec = 4'd10;
      step();
      tif.right_sec = 4'd0;
      run(8);

      // Random traffic, including codes 10-15 and blink pulses.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 36) == 0)
            set_time(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 99) == 0) begin
            tif.blink_mask  = 6'($urandom_range(0, 63));
            tif.lz_blank_en = 1'($urandom_range(0, 1));
            tif.colon_en    = 1'($urandom_range(0, 1));
         end
         tif.blink_tick = ($urandom_range(0, 49) == 0);
         step();
      end
      tif.blink_tick = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/seg7_time_scanner.md
Name: seg7_time_scanner

Overview:
- Reader side of the BCD time-digit interface driven by the seconds/minutes/hours counters.
- Takes six BCD digits (HH:MM:SS) and time-multiplexes them onto a 6-digit common-anode seven-segment display, driving active-low anodes, segments and decimal point.
- Provides per-digit blink for set mode, leading-zero blanking of the hour tens digit, and an inter-digit ghosting blank.
- Sits between the counter chain and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is selected (1 ms at 100 MHz); must be >= BLANK_CYCLES+2.
- BLANK_CYCLES, 16, clk cycles at the start of each digit slot during which all anodes are off.
- NUM_DIGITS, 6, number of scanned digits; fixed at 6 in this revision.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- right_sec  input  4  BCD seconds units (digit 0)
- left_sec  input  4  BCD seconds tens (digit 1)
- right_min  input  4  BCD minutes units (digit 2)
- left_min  input  4  BCD minutes tens (digit 3)
- right_hr  input  4  BCD hours units (digit 4)
- left_hr  input  4  BCD hours tens (digit 5)
- blink_mask  input  6  bit i = digit i blinks
- blink_tick  input  1  single-cycle pulse; toggles blink phase
- lz_blank_en  input  1  blank digit 5 when its value is 0
- colon_en  input  1  light dp on digits 2 and 4 as HH.MM.SS separators
- an  output  6  anode enables, active-low, one-hot-low when driving
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Clocking: all state on posedge clk; rst asynchronous, active-high.
- Reset: an=6'b111111, seg=7'b1111111, dp=1, refresh count=0, digit index=0, blink phase=0.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. On the wrap cycle the digit index advances 0,1,...,5,0.
- Slot timing: when count < BLANK_CYCLES, an is all-ones and seg/dp are all-ones. Otherwise an[index]=0 and all other anodes are 1.
- Output timing: an, seg and dp are registered, with one clk latency from count/index to pins. The digit value is sampled from the inputs on that same cycle; no input capture is needed because the counters are synchronous to clk.
- Blink phase: toggles on each cycle where blink_tick=1. If blink phase=1 and blink_mask[index]=1, seg=all-ones and dp=1; the anode still follows slot timing.
- Leading-zero blank: if lz_blank_en=1, index=5 and left_hr=0, seg=all-ones.
- Decode: 0-9 map to standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 8=7'b0000000. Codes 10-15 give seg=all-ones. This covers the single-cycle value-10 transient the counters produce before carry.
- dp=0 only when colon_en=1, index is 2 or 4, the slot is past the blank window, and the digit is not blink-blanked. Otherwise dp=1.
- Simultaneous events: a blink_tick on the index-advance cycle toggles the phase and advances the index in the same cycle. The new slot uses the new phase.
- Reset mid-scan: outputs go to reset values immediately, asynchronously. The scan restarts at digit 0 with a full blank window.
- Priority for seg, highest first: slot blank, blink blank, leading-zero blank, decode.

Decomposition:
- Shared package seg7_pkg:
  - segment pattern constants SEG_0..SEG_9 and SEG_OFF
  - digit index typedef (3 bits)
  - constants for the colon digit positions (2, 4)
- One combinational sub-module bcd_to_7seg: 4-bit in, 7-bit active-low out, 10-15 give SEG_OFF. Instantiated once, on the muxed digit.
- Scan counter, blink phase and output registers stay in seg7_time_scanner.

Test Plan:
- Static scan: REFRESH_DIV=40, BLANK_CYCLES=4, digits HH:MM:SS=12:34:56, all controls 0. For each digit:
  - an=all-ones for 4 cycles, then an[i]=0 for 36 cycles;
  - seg per digit: digit0=SEG_6, digit1=SEG_5, digit2=SEG_4, digit3=SEG_3, digit4=SEG_2, digit5=SEG_1;
  - index wraps 5->0.
- Reset mid-slot: assert rst while digit 3 is driven. Required response:
  - an=6'b111111 and seg=7'h7F in the same cycle, without waiting for clk;
  - after release, digit 0 is first, preceded by 4 blank cycles.
- Blink: blink_mask=6'b000011, pulse blink_tick once. Required response:
  - digits 0-1 show seg=7'h7F on the next pass while their anodes still cycle;
  - digits 2-5 are unchanged;
  - a second pulse restores SEG_6 and SEG_5.
- Leading zero and colon: left_hr=0, lz_blank_en=1, colon_en=1. Required response:
  - digit5 seg=7'h7F;
  - dp=0 only during the active windows of digits 2 and 4; dp=1 elsewhere, including blank windows.
- Invalid code: right_sec=10 for one cycle during digit 0's active window. Required response:
  - seg=7'h7F for exactly one cycle, one cycle later;
  - then seg=SEG_0 once right_sec=0.
